// File: rtl/raifes_jtag_dtm.sv
// raifes_jtag_dtm -- JTAG Debug Transport Module.
//
// Initiator end of the DMI bus. The JTAG pins are oversampled in the clk
// domain. A standard IEEE 1149.1 TAP controller selects one of the IDCODE,
// DTMCS, DMI and BYPASS data registers. A DMI DR scan turns into one DMI
// read or write towards the Debug Module.
//
// Ports:
//   clk, reset        system clock and synchronous active-high reset
//   tck, tms, tdi     JTAG pins, asynchronous to clk (2-flop synchronised)
//   tdo, tdo_oe       JTAG data out (registered) and its output enable
//   dmi_addr/wdata    request address/data, held from launch to next launch
//   dmi_en, dmi_wen   one-clk request strobe and write qualifier
//   dmi_rdata         read data returned by the DM
//   dmi_error         DM error flag, sampled at completion
//   dmi_dm_busy       DM busy; completion is first clk after dmi_en with busy low
//
// Timing rule: tck high and tck low must each last at least 3 clk periods.
module raifes_jtag_dtm #(
  parameter int          DMI_ABITS = 7,
  parameter int          DMI_DBITS = 32,
  parameter logic [31:0] IDCODE    = 32'h1000_0001,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tck,
  input  logic                 tms,
  input  logic                 tdi,
  output logic                 tdo,
  output logic                 tdo_oe,
  output logic [DMI_ABITS-1:0] dmi_addr,
  output logic [DMI_DBITS-1:0] dmi_wdata,
  input  logic [DMI_DBITS-1:0] dmi_rdata,
  output logic                 dmi_en,
  output logic                 dmi_wen,
  input  logic                 dmi_error,
  input  logic                 dmi_dm_busy
);

  // One shift register serves every DR. It is sized for the widest DR (DMI).
  localparam int DR_W = DMI_ABITS + DMI_DBITS + 2;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_t;

  // ---------------------------------------------------------------------
  // Pin synchronisers: bit 0 = tck, bit 1 = tms, bit 2 = tdi
  // ---------------------------------------------------------------------
  logic [2:0] pins_async;
  logic [2:0] pins_sync;

  assign pins_async = {tdi, tms, tck};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= pins_async[gi];
          sync_reg <= meta_reg;
        end
      end
      assign pins_sync[gi] = sync_reg;
    end
  endgenerate

  logic tck_s, tms_s, tdi_s;
  logic tck_prev_reg;
  logic tck_rise, tck_fall;

  assign tck_s    = pins_sync[0];
  assign tms_s    = pins_sync[1];
  assign tdi_s    = pins_sync[2];
  assign tck_rise = tck_s & ~tck_prev_reg;
  assign tck_fall = ~tck_s & tck_prev_reg;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  tap_state_t            tap_state_reg;
  logic [4:0]            ir_reg;
  logic [4:0]            ir_sr_reg;
  logic [DR_W-1:0]       dr_sr_reg;
  logic                  tdo_reg;
  logic                  tdo_oe_reg;
  logic [DMI_ABITS-1:0]  dmi_addr_reg;
  logic [DMI_DBITS-1:0]  dmi_wdata_reg;
  logic                  dmi_en_reg;
  logic                  dmi_wen_reg;
  logic [DMI_DBITS-1:0]  last_rdata_reg;
  logic [1:0]            dmistat_reg;
  logic                  pending_reg;

  assign tdo       = tdo_reg;
  assign tdo_oe    = tdo_oe_reg;
  assign dmi_addr  = dmi_addr_reg;
  assign dmi_wdata = dmi_wdata_reg;
  assign dmi_en    = dmi_en_reg;
  assign dmi_wen   = dmi_wen_reg;

  function automatic tap_state_t tap_step(input tap_state_t s, input logic m);
    case (s)
      TLR:      return m ? TLR      : RTI;
      RTI:      return m ? SEL_DR   : RTI;
      SEL_DR:   return m ? SEL_IR   : CAP_DR;
      CAP_DR:   return m ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: return m ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: return m ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return m ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: return m ? UPD_DR   : SHIFT_DR;
      UPD_DR:   return m ? SEL_DR   : RTI;
      SEL_IR:   return m ? TLR      : CAP_IR;
      CAP_IR:   return m ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: return m ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: return m ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return m ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: return m ? UPD_IR   : SHIFT_IR;
      UPD_IR:   return m ? SEL_DR   : RTI;
      default:  return TLR;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------
  dr_sel_t dr_sel;

  always_comb begin
    dr_sel = DR_BYPASS;
    case (ir_reg)
      5'h01:   dr_sel = DR_IDCODE;
      5'h10:   dr_sel = DR_DTMCS;
      5'h11:   dr_sel = DR_DMI;
      default: dr_sel = DR_BYPASS;
    endcase
  end

  // ---------------------------------------------------------------------
  // DMI completion, evaluated every clk. A Capture-DR on the same clk must
  // see the post-completion view, so these values feed the capture mux.
  // ---------------------------------------------------------------------
  logic                 dmi_complete;
  logic [1:0]           stat_after;
  logic [DMI_DBITS-1:0] rdata_after;
  logic                 busy_after;
  logic [1:0]           status_capture;

  assign dmi_complete   = pending_reg & ~dmi_en_reg & ~dmi_dm_busy;
  assign stat_after     = (dmi_complete && dmi_error && dmistat_reg == 2'd0) ? 2'd2 : dmistat_reg;
  assign rdata_after    = dmi_complete ? dmi_rdata : last_rdata_reg;
  assign busy_after     = pending_reg & ~dmi_complete;
  assign status_capture = busy_after ? 2'd3 : stat_after;

  logic [31:0] dtmcs_value;
  assign dtmcs_value = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_HINT, dmistat_reg,
                        6'(DMI_ABITS), 4'd1};

  logic [DR_W-1:0] dr_capture;
  logic [DR_W-1:0] dr_shifted;

  always_comb begin
    dr_capture = '0;
    case (dr_sel)
      DR_IDCODE: dr_capture = DR_W'(IDCODE);
      DR_DTMCS:  dr_capture = DR_W'(dtmcs_value);
      DR_DMI:    dr_capture = {dmi_addr_reg, rdata_after, status_capture};
      default:   dr_capture = '0;
    endcase
  end

  // tdi enters at the MSB of the selected DR's own length, so shorter DRs
  // shift out exactly their own bit count.
  always_comb begin
    dr_shifted = '0;
    case (dr_sel)
      DR_DMI:              dr_shifted = {tdi_s, dr_sr_reg[DR_W-1:1]};
      DR_IDCODE, DR_DTMCS: dr_shifted = {{(DR_W-32){1'b0}}, tdi_s, dr_sr_reg[31:1]};
      default:             dr_shifted = {{(DR_W-1){1'b0}}, tdi_s};
    endcase
  end

  // DMI DR update fields
  logic [DMI_ABITS-1:0] upd_addr;
  logic [DMI_DBITS-1:0] upd_data;
  logic [1:0]           upd_op;

  assign upd_addr = dr_sr_reg[DR_W-1 -: DMI_ABITS];
  assign upd_data = dr_sr_reg[DMI_DBITS+1:2];
  assign upd_op   = dr_sr_reg[1:0];

  logic in_shift;
  assign in_shift = (tap_state_reg == SHIFT_DR) || (tap_state_reg == SHIFT_IR);

  // ---------------------------------------------------------------------
  // TAP controller, shift path and DMI request logic
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      tck_prev_reg   <= 1'b0;
      tap_state_reg  <= TLR;
      ir_reg         <= 5'h01;
      ir_sr_reg      <= '0;
      dr_sr_reg      <= '0;
      tdo_reg        <= 1'b0;
      tdo_oe_reg     <= 1'b0;
      dmi_addr_reg   <= '0;
      dmi_wdata_reg  <= '0;
      dmi_en_reg     <= 1'b0;
      dmi_wen_reg    <= 1'b0;
      last_rdata_reg <= '0;
      dmistat_reg    <= 2'd0;
      pending_reg    <= 1'b0;
    end else begin
      tck_prev_reg <= tck_s;
      dmi_en_reg   <= 1'b0;

      if (dmi_complete) begin
        last_rdata_reg <= dmi_rdata;
        pending_reg    <= 1'b0;
        dmistat_reg    <= stat_after;
      end

      // Test-Logic-Reset resets the instruction but leaves DMI traffic alone.
      if (tap_state_reg == TLR) begin
        ir_reg <= 5'h01;
      end

      if (tck_rise) begin
        tap_state_reg <= tap_step(tap_state_reg, tms_s);
        case (tap_state_reg)
          CAP_IR:   ir_sr_reg <= 5'b00001;
          SHIFT_IR: ir_sr_reg <= {tdi_s, ir_sr_reg[4:1]};
          CAP_DR: begin
            dr_sr_reg <= dr_capture;
            if (dr_sel == DR_DMI && busy_after) begin
              dmistat_reg <= 2'd3;
            end
          end
          SHIFT_DR: dr_sr_reg <= dr_shifted;
          default: ;
        endcase
      end

      if (tck_fall) begin
        case (tap_state_reg)
          SHIFT_IR: tdo_reg <= ir_sr_reg[0];
          SHIFT_DR: tdo_reg <= dr_sr_reg[0];
          UPD_IR:   ir_reg  <= ir_sr_reg;
          UPD_DR: begin
            if (dr_sel == DR_DTMCS) begin
              if (dr_sr_reg[16] || dr_sr_reg[17]) begin
                dmistat_reg <= 2'd0;
              end
              // dmihardreset: forget the outstanding request; a late DM
              // completion then finds pending low and is ignored.
              if (dr_sr_reg[17]) begin
                pending_reg <= 1'b0;
              end
            end else if (dr_sel == DR_DMI && (upd_op == 2'd1 || upd_op == 2'd2)) begin
              if (stat_after == 2'd0 && !busy_after) begin
                dmi_en_reg    <= 1'b1;
                dmi_wen_reg   <= (upd_op == 2'd2);
                dmi_addr_reg  <= upd_addr;
                dmi_wdata_reg <= upd_data;
                pending_reg   <= 1'b1;
              end else if (busy_after) begin
                dmistat_reg <= 2'd3;
              end
            end
          end
          default: ;
        endcase
      end

      // Enable goes high with the first tdo update of a shift and drops as
      // soon as the TAP leaves the Shift state.
      if (!in_shift) begin
        tdo_oe_reg <= 1'b0;
      end else if (tck_fall) begin
        tdo_oe_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_raifes_jtag_dtm.sv
// Directed bench for raifes_jtag_dtm (DMI_ABITS=7, IDLE_HINT=1).
module tb_raifes_jtag_dtm;

  logic        clk = 1'b0;
  logic        reset;
  logic        tck, tms, tdi;
  logic        tdo, tdo_oe;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;
  logic        dmi_en, dmi_wen;
  logic        dmi_error, dmi_dm_busy;

  raifes_jtag_dtm #(
    .DMI_ABITS(7), .DMI_DBITS(32), .IDCODE(32'h1000_0001), .IDLE_HINT(3'd1)
  ) dut (
    .clk(clk), .reset(reset), .tck(tck), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_oe(tdo_oe), .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
    .dmi_rdata(dmi_rdata), .dmi_en(dmi_en), .dmi_wen(dmi_wen),
    .dmi_error(dmi_error), .dmi_dm_busy(dmi_dm_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Request monitor: counts every clk dmi_en is high, so a stretched
  // strobe shows up as an extra count.
  int          en_count = 0;
  logic        en_wen   = 1'b0;
  logic [6:0]  en_addr  = '0;
  logic [31:0] en_wdata = '0;

  always @(negedge clk) begin
    if (dmi_en === 1'b1) begin
      en_count <= en_count + 1;
      en_wen   <= dmi_wen;
      en_addr  <= dmi_addr;
      en_wdata <= dmi_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  // One tck period: tdo/tdo_oe are sampled just before the rise, i.e. the
  // value produced by the previous fall.
  task automatic jclk(input logic ms, input logic di, output logic do_s, output logic oe_s);
    @(negedge clk);
    tms = ms;
    tdi = di;
    repeat (4) @(negedge clk);
    do_s = tdo;
    oe_s = tdo_oe;
    tck  = 1'b1;
    repeat (4) @(negedge clk);
    tck  = 1'b0;
  endtask

  task automatic tap_reset();
    logic d, o;
    for (int i = 0; i < 5; i++) jclk(1'b1, 1'b0, d, o);
    jclk(1'b0, 1'b0, d, o);
  endtask

  // From Run-Test/Idle, scan len bits through the DR, back to Run-Test/Idle.
  task automatic scan_dr(input logic [63:0] din, input int len,
                         output logic [63:0] dout, output logic oe_ok);
    logic d, o;
    dout  = '0;
    oe_ok = 1'b1;
    jclk(1'b1, 1'b0, d, o);
    jclk(1'b0, 1'b0, d, o);
    jclk(1'b0, 1'b0, d, o);
    if (o !== 1'b0) oe_ok = 1'b0;
    for (int i = 0; i < len; i++) begin
      jclk(i == len - 1, din[i], d, o);
      dout[i] = d;
      if (o !== 1'b1) oe_ok = 1'b0;
    end
    jclk(1'b1, 1'b0, d, o);
    if (o !== 1'b0) oe_ok = 1'b0;
    jclk(1'b0, 1'b0, d, o);
    if (o !== 1'b0) oe_ok = 1'b0;
  endtask

  task automatic scan_ir(input logic [4:0] ir, output logic [4:0] cap);
    logic d, o;
    jclk(1'b1, 1'b0, d, o);
    jclk(1'b1, 1'b0, d, o);
    jclk(1'b0, 1'b0, d, o);
    jclk(1'b0, 1'b0, d, o);
    for (int i = 0; i < 5; i++) begin
      jclk(i == 4, ir[i], d, o);
      cap[i] = d;
    end
    jclk(1'b1, 1'b0, d, o);
    jclk(1'b0, 1'b0, d, o);
  endtask

  logic [63:0] dout;
  logic        oe_ok;
  logic [4:0]  irc;

  initial begin
    reset = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0;
    dmi_rdata = '0; dmi_error = 1'b0; dmi_dm_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_tdo_oe", 64'(tdo_oe), 64'd0);
    check("rst_dmi_en", 64'(dmi_en), 64'd0);
    check("rst_dmi_wen", 64'(dmi_wen), 64'd0);
    check("rst_dmi_addr", 64'(dmi_addr), 64'd0);
    check("rst_dmi_wdata", 64'(dmi_wdata), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // T1: IDCODE after Test-Logic-Reset
    tap_reset();
    scan_dr(64'd0, 32, dout, oe_ok);
    check("t1_idcode", dout, 64'h1000_0001);
    check("t1_tdo_oe_window", 64'(oe_ok), 64'd1);

    // T2: DTMCS read
    scan_ir(5'h10, irc);
    check("t2_ir_capture", 64'(irc), 64'd1);
    scan_dr(64'd0, 32, dout, oe_ok);
    check("t2_dtmcs", dout, 64'h0000_1071);

    // T3: DMI write
    scan_ir(5'h11, irc);
    scan_dr(dmi_word(7'h10, 32'h1, 2'd2), 41, dout, oe_ok);
    check("t3_capture", dout, dmi_word(7'h00, 32'h0, 2'd0));
    check("t3_dmi_oe_window", 64'(oe_ok), 64'd1);
    check("t3_en_count", 64'(en_count), 64'd1);
    check("t3_wen", 64'(en_wen), 64'd1);
    check("t3_addr", 64'(en_addr), 64'h10);
    check("t3_wdata", 64'(en_wdata), 64'h1);
    check("t3_addr_hold", 64'(dmi_addr), 64'h10);
    scan_dr(64'd0, 41, dout, oe_ok);
    check("t3_next_capture", dout, dmi_word(7'h10, 32'h0, 2'd0));
    check("t3_noop_no_en", 64'(en_count), 64'd1);

    // T4: read with DM busy for 20 clks
    dmi_rdata = 32'hCAFE_F00D;
    dmi_dm_busy = 1'b1;
    scan_dr(dmi_word(7'h11, 32'h0, 2'd1), 41, dout, oe_ok);
    check("t4_en_count", 64'(en_count), 64'd2);
    check("t4_wen", 64'(en_wen), 64'd0);
    check("t4_addr", 64'(en_addr), 64'h11);
    repeat (20) @(negedge clk);
    dmi_dm_busy = 1'b0;
    repeat (40) @(negedge clk);
    scan_dr(64'd0, 41, dout, oe_ok);
    check("t4_capture", dout, dmi_word(7'h11, 32'hCAFE_F00D, 2'd0));

    // T5: second scan while the DM stays busy
    dmi_dm_busy = 1'b1;
    scan_dr(dmi_word(7'h12, 32'h0, 2'd1), 41, dout, oe_ok);
    check("t5_first_capture", dout, dmi_word(7'h11, 32'hCAFE_F00D, 2'd0));
    check("t5_en_count", 64'(en_count), 64'd3);
    dmi_rdata = 32'h1234_5678;
    scan_dr(dmi_word(7'h13, 32'hAAAA_5555, 2'd2), 41, dout, oe_ok);
    check("t5_busy_capture", dout, dmi_word(7'h12, 32'hCAFE_F00D, 2'd3));
    check("t5_no_second_en", 64'(en_count), 64'd3);
    check("t5_addr_hold", 64'(dmi_addr), 64'h12);
    scan_ir(5'h10, irc);
    scan_dr(64'h0001_0000, 32, dout, oe_ok);
    check("t5_dtmcs_busy", dout, 64'h0000_1C71);
    scan_dr(64'd0, 32, dout, oe_ok);
    check("t5_dtmcs_cleared", dout, 64'h0000_1071);
    dmi_dm_busy = 1'b0;
    repeat (5) @(negedge clk);
    scan_ir(5'h11, irc);
    scan_dr(64'd0, 41, dout, oe_ok);
    check("t5_late_complete", dout, dmi_word(7'h12, 32'h1234_5678, 2'd0));

    // dmihardreset abandons a pending read; its completion is ignored
    dmi_dm_busy = 1'b1;
    scan_dr(dmi_word(7'h14, 32'h0, 2'd1), 41, dout, oe_ok);
    check("hr_en_count", 64'(en_count), 64'd4);
    scan_ir(5'h10, irc);
    scan_dr(64'h0002_0000, 32, dout, oe_ok);
    check("hr_dtmcs", dout, 64'h0000_1071);
    dmi_rdata = 32'hDEAD_BEEF;
    dmi_dm_busy = 1'b0;
    repeat (5) @(negedge clk);
    scan_ir(5'h11, irc);
    scan_dr(64'd0, 41, dout, oe_ok);
    check("hr_ignored", dout, dmi_word(7'h14, 32'h1234_5678, 2'd0));

    // T6: DM error is sticky and blocks further launches
    dmi_error = 1'b1;
    dmi_rdata = 32'h0BAD_F00D;
    scan_dr(dmi_word(7'h15, 32'h0, 2'd1), 41, dout, oe_ok);
    check("t6_en_count", 64'(en_count), 64'd5);
    dmi_error = 1'b0;
    scan_dr(dmi_word(7'h16, 32'h1, 2'd2), 41, dout, oe_ok);
    check("t6_err_capture", dout, dmi_word(7'h15, 32'h0BAD_F00D, 2'd2));
    check("t6_blocked", 64'(en_count), 64'd5);
    scan_dr(64'd0, 41, dout, oe_ok);
    check("t6_err_sticky", dout, dmi_word(7'h15, 32'h0BAD_F00D, 2'd2));

    // Reset in the middle of a pending transaction
    scan_ir(5'h10, irc);
    scan_dr(64'h0001_0000, 32, dout, oe_ok);
    check("t6_dtmcs_err", dout, 64'h0000_1871);
    scan_ir(5'h11, irc);
    dmi_dm_busy = 1'b1;
    scan_dr(dmi_word(7'h17, 32'h0, 2'd1), 41, dout, oe_ok);
    check("t6_relaunch", 64'(en_count), 64'd6);
    check("t6_addr", 64'(dmi_addr), 64'h17);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_tdo_oe", 64'(tdo_oe), 64'd0);
    check("mid_rst_dmi_en", 64'(dmi_en), 64'd0);
    check("mid_rst_dmi_addr", 64'(dmi_addr), 64'd0);
    check("mid_rst_dmi_wdata", 64'(dmi_wdata), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tap_reset();
    scan_dr(64'd0, 32, dout, oe_ok);
    check("mid_rst_ir_idcode", dout, 64'h1000_0001);
    scan_ir(5'h11, irc);
    scan_dr(64'd0, 41, dout, oe_ok);
    check("mid_rst_no_pending", dout[1:0], 64'd0);
    check("mid_rst_last_addr", dout[40:34], 64'd0);
    dmi_dm_busy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
